// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS frequency-sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dds_pkg;

    localparam int FW_DEF = 16;
    localparam int CW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DWELL = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } sweep_state_t;

    // The DDS core runs (en high) for the whole time a frequency is being presented.
    function automatic logic st_en(input sweep_state_t s);
        return (s == LOAD) || (s == DWELL) || (s == STEP);
    endfunction

    // Busy covers exactly the states in which a frequency is being presented.
    function automatic logic st_busy(input sweep_state_t s);
        return (s == LOAD) || (s == DWELL) || (s == STEP);
    endfunction

endpackage

// File: rtl/dds_dwell_cnt.sv
// Loadable down-counter with zero flag that times the hold of each sweep frequency.
// Latency: load and decrement take effect on the next clock; zero flag is combinational from the count.
// Backpressure: none; the counter saturates at zero rather than wrapping.
module dds_dwell_cnt #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;

    // Load has priority over decrement; stop at zero so an idle counter stays quiet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding tuning word and en/load to the DDS core.
// Latency: start to first load is one cycle; each frequency lasts dwell+3 cycles.
// Backpressure: none; start is only honoured in IDLE, abort wins in every state.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW = FW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          loop_i,
    input  logic [FW-1:0] f_start_i,
    input  logic [FW-1:0] f_stop_i,
    input  logic [FW-1:0] f_step_i,
    input  logic [CW-1:0] dwell_i,
    output logic          dds_en_o,
    output logic          dds_load_o,
    output logic [FW-1:0] freq_word_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    sweep_state_t  state_q, state_d;
    logic [FW-1:0] freq_q, freq_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          en_q, load_q, busy_q;

    // Configuration frozen at start so register writes mid-sweep cannot disturb it.
    logic [FW-1:0] fstart_q, fstop_q, fstep_q;
    logic [CW-1:0] dwell_q;
    logic          loop_q;

    logic          cfg_ok;
    logic          accept;
    logic [FW:0]   nxt_sum;
    logic          dwell_zero;

    assign cfg_ok = (f_step_i != '0) && (f_stop_i >= f_start_i);
    assign accept = (state_q == IDLE) && start_i && !abort_i && cfg_ok;

    // One extra bit so a carry out of the tuning word reads as overshooting f_stop.
    assign nxt_sum = {1'b0, freq_q} + {1'b0, fstep_q};

    dds_dwell_cnt #(
        .CW(CW)
    ) u_dwell (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q == LOAD),
        .load_val_i(dwell_q),
        .dec_i     (state_q == DWELL),
        .zero_o    (dwell_zero)
    );

    // Next-state and next-word decision; abort overrides everything, including start and err.
    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        err_d   = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            freq_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (cfg_ok) begin
                            freq_d  = f_start_i;
                            state_d = LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state_d = DWELL;
                end
                DWELL: begin
                    if (dwell_zero) begin
                        state_d = STEP;
                    end
                end
                STEP: begin
                    if (nxt_sum <= {1'b0, fstop_q}) begin
                        freq_d  = nxt_sum[FW-1:0];
                        state_d = LOAD;
                    end else if (loop_q) begin
                        freq_d  = fstart_q;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        done_d = (state_d == DONE);
    end

    // State, word and Moore outputs registered together so the outputs line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            freq_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            fstart_q <= '0;
            fstop_q  <= '0;
            fstep_q  <= '0;
            dwell_q  <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= st_en(state_d);
            load_q  <= (state_d == LOAD);
            busy_q  <= st_busy(state_d);
            if (accept) begin
                fstart_q <= f_start_i;
                fstop_q  <= f_stop_i;
                fstep_q  <= f_step_i;
                dwell_q  <= dwell_i;
                loop_q   <= loop_i;
            end
        end
    end

    assign dds_en_o    = en_q;
    assign dds_load_o  = load_q;
    assign freq_word_o = freq_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for the DDS sweep sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_dds_sweep_ctrl;

    localparam int FW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          loop_i = 1'b0;
    logic [FW-1:0] f_start_i = '0;
    logic [FW-1:0] f_stop_i = '0;
    logic [FW-1:0] f_step_i = '0;
    logic [CW-1:0] dwell_i = '0;
    logic          dds_en_o, dds_load_o, busy_o, done_o, err_o;
    logic [FW-1:0] freq_word_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int            ld_cyc[$];
    logic [FW-1:0] ld_frq[$];
    int            dn_cyc[$];
    int            err_n = 0;
    bit            busy_seen = 1'b0;

    dds_sweep_ctrl #(.FW(FW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .loop_i     (loop_i),
        .f_start_i  (f_start_i),
        .f_stop_i   (f_stop_i),
        .f_step_i   (f_step_i),
        .dwell_i    (dwell_i),
        .dds_en_o   (dds_en_o),
        .dds_load_o (dds_load_o),
        .freq_word_o(freq_word_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record observable events away from the active edge.
    always @(negedge clk) begin
        if (dds_load_o) begin
            ld_cyc.push_back(cyc);
            ld_frq.push_back(freq_word_o);
        end
        if (done_o) dn_cyc.push_back(cyc);
        if (err_o) err_n++;
        if (busy_o) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ld_cyc.delete();
        ld_frq.delete();
        dn_cyc.delete();
        err_n = 0;
        busy_seen = 1'b0;
    endtask

    // Pulse start for one cycle, then scramble the config inputs to prove they were captured.
    task automatic go(input logic [FW-1:0] s, input logic [FW-1:0] e, input logic [FW-1:0] st,
                      input logic [CW-1:0] dw, input logic lp, input logic ab);
        clr();
        @(negedge clk);
        f_start_i = s;
        f_stop_i  = e;
        f_step_i  = st;
        dwell_i   = dw;
        loop_i    = lp;
        abort_i   = ab;
        start_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
        abort_i   = 1'b0;
        f_start_i = 16'h1234;
        f_stop_i  = 16'h0001;
        f_step_i  = '0;
        dwell_i   = 16'd7;
        loop_i    = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int n = 0;
        while (dn_cyc.size() == 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, dn_cyc.size() != 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_sweep(input string tag, input int nld, input int base, input int step,
                               input int gap, input int ndone);
        chk({tag, "_nload"}, ld_frq.size(), nld);
        for (int i = 0; i < ld_frq.size() && i < nld; i++)
            chk({tag, "_frq"}, ld_frq[i], base + step * i);
        for (int i = 1; i < ld_cyc.size(); i++)
            chk({tag, "_gap"}, ld_cyc[i] - ld_cyc[i-1], gap);
        chk({tag, "_ndone"}, dn_cyc.size(), ndone);
        if (dn_cyc.size() > 0 && ld_cyc.size() > 0)
            chk({tag, "_done_lat"}, dn_cyc[0] - ld_cyc[$], gap);
        chk({tag, "_err"}, err_n, 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_en"},   dds_en_o, 0);
        chk({tag, "_load"}, dds_load_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_freq"}, freq_word_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"},  err_o, 0);
    endtask

    initial begin
        int n;
        int nl;

        // Reset state, asynchronously and with the clock running.
        #2 rst = 1'b0;
        #1 chk_quiet("rst_async");
        repeat (3) @(negedge clk);
        chk_quiet("rst_hold");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single sweep, reachable stop: 100,110,120,130 every 5 cycles.
        go(16'd100, 16'd130, 16'd10, 16'd2, 1'b0, 1'b0);
        wait_done("s1", 100);
        check_sweep("s1", 4, 100, 10, 5, 1);
        chk("s1_hold", freq_word_o, 130);
        chk("s1_idle_busy", busy_o, 0);

        // Unreachable stop: last word is 120.
        go(16'd100, 16'd125, 16'd10, 16'd0, 1'b0, 1'b0);
        wait_done("s2", 100);
        check_sweep("s2", 3, 100, 10, 3, 1);

        // Start equal to stop in single mode: one load then done.
        go(16'd77, 16'd77, 16'd5, 16'd1, 1'b0, 1'b0);
        wait_done("s3", 100);
        check_sweep("s3", 1, 77, 0, 4, 1);

        // Loop mode: 0,10,20,0,10,... with no done.
        go(16'd0, 16'd20, 16'd10, 16'd1, 1'b1, 1'b0);
        repeat (25) @(negedge clk);
        chk("lp_nload_min", ld_frq.size() >= 5, 1);
        for (int i = 0; i < 5 && i < ld_frq.size(); i++)
            chk("lp_frq", ld_frq[i], (i % 3) * 10);
        for (int i = 1; i < ld_cyc.size(); i++)
            chk("lp_gap", ld_cyc[i] - ld_cyc[i-1], 4);
        chk("lp_ndone", dn_cyc.size(), 0);

        // Abort in the first DWELL cycle after a load.
        n = 0;
        while (!dds_load_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ab_load_seen", dds_load_o, 1);
        @(negedge clk);
        chk("ab_in_dwell", {dds_en_o, dds_load_o, busy_o}, 3'b101);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk_quiet("ab_idle");
        nl = ld_frq.size();
        repeat (10) @(negedge clk);
        chk("ab_no_more_loads", ld_frq.size(), nl);
        chk("ab_no_done", dn_cyc.size(), 0);

        // Invalid configs and start colliding with abort.
        go(16'd100, 16'd200, 16'd0, 16'd2, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("inv_step_err", err_n, 1);
        chk("inv_step_busy", busy_seen, 0);
        chk("inv_step_nload", ld_frq.size(), 0);

        go(16'd50, 16'd40, 16'd10, 16'd2, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("inv_order_err", err_n, 1);
        chk("inv_order_busy", busy_seen, 0);

        go(16'd100, 16'd200, 16'd10, 16'd2, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("sa_err", err_n, 0);
        chk("sa_busy", busy_seen, 0);
        chk("sa_nload", ld_frq.size(), 0);

        // Carry out of the tuning word ends the sweep instead of wrapping.
        go(16'hFFF0, 16'hFFFF, 16'h0010, 16'd0, 1'b0, 1'b0);
        wait_done("cy", 50);
        check_sweep("cy", 1, 32'hFFF0, 0, 3, 1);
        chk("cy_hold", freq_word_o, 16'hFFF0);

        // Reset during DWELL, then a normal sweep afterwards.
        go(16'd100, 16'd130, 16'd10, 16'd5, 1'b0, 1'b0);
        n = 0;
        while (ld_frq.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("rm_in_dwell", {dds_en_o, dds_load_o, busy_o}, 3'b101);
        #2 rst = 1'b0;
        #1 chk_quiet("rm_async");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("rm_after");

        go(16'd100, 16'd130, 16'd10, 16'd2, 1'b0, 1'b0);
        wait_done("rs", 100);
        check_sweep("rs", 4, 100, 10, 5, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
